spi_cmd_ctrl: RTL and testbench
===============================

Name: spi_cmd_ctrl

Overview:
- Transaction controller placed between the SPI slave and the NPU register/memory bus.
- Consumes the 16-bit words the slave delivers and decodes the first word of each transaction as a command.
- Write commands: issues burst writes to the register bus.
- Read commands: fetches register data and preloads the slave shift register, so the data shifts out on MISO during the host's next 16-bit frame.
- Also owns transaction timeout and overrun detection.

Parameters:
- DATA_WIDTH, `NPU_DATA_WIDTH (16), SPI word and register data width.
- ADDR_WIDTH, 8, register address width; must be ≤ 8.
- TIMEOUT_WIDTH, 16, width of the inter-word timeout counter.
- TIMEOUT_CYCLES, 16'hFFFF, clk cycles allowed between words mid-transaction.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- spi_word_valid  in  1  one-cycle strobe: a complete 16-bit word was received (slave FIFO write enable).
- spi_word  in  DATA_WIDTH  received word; valid while spi_word_valid=1.
- spi_load  out  1  one-cycle pulse: load spi_load_data into the slave shift register.
- spi_load_data  out  DATA_WIDTH  read data for MISO.
- reg_req  out  1  bus request; held until reg_ack.
- reg_we  out  1  1=write, 0=read; stable while reg_req=1.
- reg_addr  out  ADDR_WIDTH  bus address; stable while reg_req=1.
- reg_wdata  out  DATA_WIDTH  write data; stable while reg_req=1.
- reg_ack  in  1  one-cycle completion; reg_rdata is valid with it on reads.
- reg_rdata  in  DATA_WIDTH  read data.
- busy  out  1  1 whenever state != IDLE.
- err_overrun  out  1  sticky: a word arrived while a bus access was pending.
- err_timeout  out  1  sticky: the inter-word timeout expired.
- err_clear  in  1  clears both sticky flags.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- Command word format:
  - bit15 rw: 1=write, 0=read.
  - bits14:8 len_m1: burst length minus 1, giving 1..128 words.
  - bits7:0 start_addr; the low ADDR_WIDTH bits are used.
- State machine:
  - IDLE: on spi_word_valid, latch addr and remaining=len_m1. Go to WR_WAIT if rw=1, else RD_REQ.
  - WR_WAIT: on spi_word_valid, latch reg_wdata and go to WR_REQ. reg_req asserts the cycle after the state is entered.
  - WR_REQ: reg_req=1, reg_we=1. On reg_ack:
    - if remaining==0, go to IDLE;
    - else decrement remaining, increment addr, go to WR_WAIT.
  - RD_REQ: reg_req=1, reg_we=0. On reg_ack, capture reg_rdata into spi_load_data and go to RD_LOAD.
  - RD_LOAD: spi_load=1 for exactly one cycle, then go to RD_WAIT.
  - RD_WAIT: the host clocks a dummy word, which shifts the data out. On spi_word_valid:
    - if remaining==0, go to IDLE;
    - else decrement remaining, increment addr, go to RD_REQ.
- Latency:
  - spi_load fires 2 cycles after reg_ack.
  - The host must leave ≥ (bus latency + 3) cycles between the command/dummy word and the first SCLK edge of the next frame.
- Address: increments modulo 2^ADDR_WIDTH; 8'hFF wraps to 8'h00 with no error.
- Overrun: spi_word_valid in WR_REQ or RD_REQ sets err_overrun and the word is dropped. The pending access completes normally and the state does not change.
- Timeout:
  - The counter runs in WR_WAIT and RD_WAIT, and clears on every state change and every spi_word_valid.
  - On reaching TIMEOUT_CYCLES-1, set err_timeout and go to IDLE; no bus access is issued.
  - REQ states have no timeout; the bus must eventually ack.
- Sticky flags:
  - err_clear has priority over a set in the same cycle, i.e. the flag reads 0 next cycle.
  - Flags do not block new transactions.
- Simultaneous spi_word_valid and reg_ack in a REQ state: the ack is processed, the word counts as overrun.
- reset mid-transaction: immediate return to IDLE with all outputs 0. An in-flight reg_req is dropped, and the bus must tolerate this.

Decomposition:
- Shared npu_params package gains:
  - state encodings SPI_CTRL_IDLE..SPI_CTRL_RD_WAIT (3-bit);
  - command field positions SPI_CMD_RW_BIT=15, SPI_CMD_LEN_MSB/LSB=14/8, SPI_CMD_ADDR_MSB/LSB=7/0.
- Timeout counter reuses the existing counter module; state register reuses dff.
- No new sub-module is needed.

Test Plan:
- Single write: word 16'h8012, then 16'hBEEF, ack 2 cycles later -> one reg_req with we=1, addr=8'h12, wdata=16'hBEEF; busy returns to 0 after the ack.
- Burst read: 16'h02FE (3 words from 8'hFE), rdata 16'h1111/2222/3333 -> addrs 8'hFE, 8'hFF, 8'h00 (wrap); three spi_load pulses carrying those values, each 2 cycles after its ack.
- Overrun: write command, data word, second word during WR_REQ before ack -> err_overrun=1, exactly one write issued; err_clear drops the flag.
- Timeout: TIMEOUT_CYCLES=16, command 16'h8100, no further words -> err_timeout=1 after 16 idle cycles, state IDLE, zero reg_req.
- Reset mid-burst: reset asserted in RD_REQ -> next cycle reg_req=0, busy=0, spi_load=0; a new 16'h8005 + data then completes normally.
- Max burst: 16'hFF00 write with 128 data words -> 128 acks, addrs 0..127, return to IDLE.

Source files
------------

// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared definitions for the SPI command controller.
//   - NPU_DATA_WIDTH : default SPI word / register data width
//   - SPI_CMD_*      : bit positions of the fields inside a command word
//   - spi_ctrl_state_t : controller state encoding (3 bits)
package spi_cmd_ctrl_pkg;

  localparam int NPU_DATA_WIDTH = 16;

  // Command word layout: {rw, len_m1[6:0], start_addr[7:0]}
  localparam int SPI_CMD_RW_BIT   = 15;
  localparam int SPI_CMD_LEN_MSB  = 14;
  localparam int SPI_CMD_LEN_LSB  = 8;
  localparam int SPI_CMD_ADDR_MSB = 7;
  localparam int SPI_CMD_ADDR_LSB = 0;

  localparam int SPI_CMD_LEN_W  = SPI_CMD_LEN_MSB - SPI_CMD_LEN_LSB + 1;
  localparam int SPI_CMD_ADDR_W = SPI_CMD_ADDR_MSB - SPI_CMD_ADDR_LSB + 1;

  typedef enum logic [2:0] {
    SPI_CTRL_IDLE    = 3'd0,
    SPI_CTRL_WR_WAIT = 3'd1,
    SPI_CTRL_WR_REQ  = 3'd2,
    SPI_CTRL_RD_REQ  = 3'd3,
    SPI_CTRL_RD_LOAD = 3'd4,
    SPI_CTRL_RD_WAIT = 3'd5
  } spi_ctrl_state_t;

endpackage

// File: rtl/spi_cmd_ctrl.sv
// SPI command controller: sits between the SPI slave word interface and the
// NPU register bus. The first word of a transaction is a command
// {rw, len_m1, start_addr}; writes then take one data word per bus write,
// reads fetch register data and preload the slave shift register so it
// shifts out during the host's next (dummy) frame.
//
// Ports
//   clk, reset                 : single clock, synchronous active-high reset
//   spi_word_valid, spi_word   : received-word strobe and data from the slave
//   spi_load, spi_load_data    : one-cycle preload of the slave shift register
//   reg_req/we/addr/wdata      : bus request, held until reg_ack
//   reg_ack, reg_rdata         : bus completion and read data
//   busy                       : controller not idle
//   err_overrun, err_timeout   : sticky error flags, cleared by err_clear
module spi_cmd_ctrl
  import spi_cmd_ctrl_pkg::*;
#(
  parameter int          DATA_WIDTH     = NPU_DATA_WIDTH,
  parameter int          ADDR_WIDTH     = 8,
  parameter int          TIMEOUT_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 32'h0000_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_word_valid,
  input  logic [DATA_WIDTH-1:0] spi_word,
  output logic                  spi_load,
  output logic [DATA_WIDTH-1:0] spi_load_data,
  output logic                  reg_req,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic                  reg_ack,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  busy,
  output logic                  err_overrun,
  output logic                  err_timeout,
  input  logic                  err_clear
);

  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  spi_ctrl_state_t           state, state_nxt;
  logic [SPI_CMD_LEN_W-1:0]  remaining;
  logic [TIMEOUT_WIDTH-1:0]  to_cnt;

  logic                      cmd_rw;
  logic [SPI_CMD_LEN_W-1:0]  cmd_len_m1;
  logic [SPI_CMD_ADDR_W-1:0] cmd_addr;

  logic cmd_take;
  logic wdata_take;
  logic rdata_take;
  logic advance;
  logic timeout_hit;
  logic overrun_hit;
  logic wait_state;

  assign cmd_rw     = spi_word[SPI_CMD_RW_BIT];
  assign cmd_len_m1 = spi_word[SPI_CMD_LEN_MSB:SPI_CMD_LEN_LSB];
  assign cmd_addr   = spi_word[SPI_CMD_ADDR_MSB:SPI_CMD_ADDR_LSB];

  assign wait_state = (state == SPI_CTRL_WR_WAIT) || (state == SPI_CTRL_RD_WAIT);

  assign busy    = (state != SPI_CTRL_IDLE);
  assign reg_req = (state == SPI_CTRL_WR_REQ) || (state == SPI_CTRL_RD_REQ);
  assign reg_we  = (state == SPI_CTRL_WR_REQ);

  // Next-state decode. A word arriving in a REQ state is never consumed:
  // the pending access finishes on its own ack and the word is flagged.
  always_comb begin
    state_nxt   = state;
    cmd_take    = 1'b0;
    wdata_take  = 1'b0;
    rdata_take  = 1'b0;
    advance     = 1'b0;
    timeout_hit = 1'b0;
    overrun_hit = 1'b0;
    case (state)
      SPI_CTRL_IDLE: begin
        if (spi_word_valid) begin
          cmd_take  = 1'b1;
          state_nxt = cmd_rw ? SPI_CTRL_WR_WAIT : SPI_CTRL_RD_REQ;
        end
      end
      SPI_CTRL_WR_WAIT: begin
        if (spi_word_valid) begin
          wdata_take = 1'b1;
          state_nxt  = SPI_CTRL_WR_REQ;
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = SPI_CTRL_IDLE;
        end
      end
      SPI_CTRL_WR_REQ: begin
        overrun_hit = spi_word_valid;
        if (reg_ack) begin
          if (remaining == '0) begin
            state_nxt = SPI_CTRL_IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = SPI_CTRL_WR_WAIT;
          end
        end
      end
      SPI_CTRL_RD_REQ: begin
        overrun_hit = spi_word_valid;
        if (reg_ack) begin
          rdata_take = 1'b1;
          state_nxt  = SPI_CTRL_RD_LOAD;
        end
      end
      SPI_CTRL_RD_LOAD: begin
        state_nxt = SPI_CTRL_RD_WAIT;
      end
      SPI_CTRL_RD_WAIT: begin
        // The dummy word that shifted the read data out also advances the burst.
        if (spi_word_valid) begin
          if (remaining == '0) begin
            state_nxt = SPI_CTRL_IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = SPI_CTRL_RD_REQ;
          end
        end else if (to_cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = SPI_CTRL_IDLE;
        end
      end
      default: begin
        state_nxt = SPI_CTRL_IDLE;
      end
    endcase
  end

  // ---- p0 -> p1 : state, address/length, data capture, error flags ----
  // spi_load is registered off RD_LOAD, so it lands two cycles after reg_ack
  // with spi_load_data already stable for a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SPI_CTRL_IDLE;
      remaining     <= '0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      spi_load_data <= '0;
      spi_load      <= 1'b0;
      to_cnt        <= '0;
      err_overrun   <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state    <= state_nxt;
      spi_load <= (state == SPI_CTRL_RD_LOAD);

      if (cmd_take) begin
        reg_addr  <= cmd_addr[ADDR_WIDTH-1:0];
        remaining <= cmd_len_m1;
      end else if (advance) begin
        reg_addr  <= reg_addr + ADDR_WIDTH'(1);
        remaining <= remaining - SPI_CMD_LEN_W'(1);
      end

      if (wdata_take) begin
        reg_wdata <= spi_word;
      end
      if (rdata_take) begin
        spi_load_data <= reg_rdata;
      end

      // Inter-word timeout: only counts while waiting for the host.
      if ((state_nxt != state) || spi_word_valid || !wait_state) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TIMEOUT_WIDTH'(1);
      end

      if (err_clear) begin
        err_overrun <= 1'b0;
      end else if (overrun_hit) begin
        err_overrun <= 1'b1;
      end

      if (err_clear) begin
        err_timeout <= 1'b0;
      end else if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: a host model drives command/data/dummy
// words, a bus responder acks requests after a programmable latency and logs
// every access, and a transaction-level model predicts the accesses and the
// read data that must be preloaded into the slave.
module tb_spi_cmd_ctrl;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          spi_word_valid;
  logic [DW-1:0] spi_word;
  logic          spi_load;
  logic [DW-1:0] spi_load_data;
  logic          reg_req;
  logic          reg_we;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          reg_ack;
  logic [DW-1:0] reg_rdata;
  logic          busy;
  logic          err_overrun;
  logic          err_timeout;
  logic          err_clear;

  spi_cmd_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_WIDTH (TW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .spi_word_valid(spi_word_valid),
    .spi_word      (spi_word),
    .spi_load      (spi_load),
    .spi_load_data (spi_load_data),
    .reg_req       (reg_req),
    .reg_we        (reg_we),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_ack       (reg_ack),
    .reg_rdata     (reg_rdata),
    .busy          (busy),
    .err_overrun   (err_overrun),
    .err_timeout   (err_timeout),
    .err_clear     (err_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } acc_t;

  acc_t          acc_log[$];
  acc_t          exp_acc[$];
  logic [DW-1:0] load_val[$];
  int            load_cyc[$];
  logic [DW-1:0] exp_load[$];
  logic [DW-1:0] host_data[$];
  logic [DW-1:0] mem [256];

  int checks = 0;
  int errors = 0;
  int ack_lat = 2;
  int unstable = 0;

  // Bus responder: ack after ack_lat extra cycles, log the access, and flag
  // any change of the request fields while it is held.
  initial begin : responder
    int   wait_cnt;
    acc_t held;
    wait_cnt = 0;
    held = '{we: 1'b0, addr: '0, wdata: '0, cyc: 0};
    reg_ack = 1'b0;
    reg_rdata = '0;
    forever begin
      @(negedge clk);
      reg_ack = 1'b0;
      reg_rdata = 16'($urandom);
      if (reg_req) begin
        if (wait_cnt == 0) begin
          held.we = reg_we; held.addr = reg_addr; held.wdata = reg_wdata;
        end else if (held.we !== reg_we || held.addr !== reg_addr ||
                     (reg_we && held.wdata !== reg_wdata)) begin
          unstable++;
        end
        if (wait_cnt >= ack_lat) begin
          reg_ack = 1'b1;
          if (!reg_we) reg_rdata = mem[reg_addr];
          held.cyc = cyc;
          acc_log.push_back(held);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (spi_load) begin
      load_val.push_back(spi_load_data);
      load_cyc.push_back(cyc);
    end
  end

  task automatic clear_logs();
    acc_log.delete(); exp_acc.delete(); load_val.delete();
    load_cyc.delete(); exp_load.delete(); unstable = 0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    @(negedge clk);
    spi_word = w; spi_word_valid = 1'b1;
    @(negedge clk);
    spi_word_valid = 1'b0;
  endtask

  // kind 0: accesses >= target, 1: loads >= target, 2: idle, 3: reg_req seen
  task automatic wait_until(input int kind, input int target, input int budget, output bit ok);
    bit c;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      case (kind)
        0:       c = (acc_log.size() >= target);
        1:       c = (load_val.size() >= target);
        2:       c = !busy;
        default: c = reg_req;
      endcase
      if (c) begin ok = 1'b1; return; end
    end
  endtask

  // Host side of one transaction; write data comes from host_data.
  task automatic host_txn(input logic [DW-1:0] cmd, output bit ok);
    int n;
    int base;
    n = int'(cmd[14:8]) + 1;
    ok = 1'b1;
    if (cmd[15]) begin
      send_word(cmd);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        base = acc_log.size();
        send_word(host_data[i]);
        wait_until(0, base + 1, 64, ok);
        if (!ok) return;
      end
    end else begin
      base = load_val.size();
      send_word(cmd);
      for (int i = 0; i < n; i++) begin
        wait_until(1, base + i + 1, 64, ok);
        if (!ok) return;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        send_word(16'($urandom));
      end
    end
    wait_until(2, 0, 64, ok);
  endtask

  // Reference: a burst of len_m1+1 accesses from start_addr, 8-bit wrapping.
  function automatic void model_txn(input logic [DW-1:0] cmd);
    int n;
    logic [AW-1:0] a;
    n = int'(cmd[14:8]) + 1;
    a = cmd[7:0];
    for (int i = 0; i < n; i++) begin
      acc_t e;
      e.we = cmd[15]; e.addr = a; e.cyc = 0;
      e.wdata = cmd[15] ? host_data[i] : '0;
      exp_acc.push_back(e);
      if (!cmd[15]) exp_load.push_back(mem[a]);
      a = a + 8'd1;
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, reg_req, reg_we, spi_load, err_overrun, err_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {busy, reg_req, reg_we, spi_load, err_overrun, err_timeout});
    end
    checks++;
    if (reg_addr !== '0 || reg_wdata !== '0 || spi_load_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr %h wdata %h load %h expected 0",
               reg_addr, reg_wdata, spi_load_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    bit ok;
    clear_logs(); ack_lat = 2;
    host_data.delete(); host_data.push_back(16'hBEEF);
    host_txn(16'h8012, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_write_done: got stuck expected idle"); end
    checks++;
    if (acc_log.size() != 1) begin
      errors++; $display("FAIL single_write_count: got %0d expected 1", acc_log.size());
    end else begin
      checks++;
      if (acc_log[0].we !== 1'b1 || acc_log[0].addr !== 8'h12 || acc_log[0].wdata !== 16'hBEEF) begin
        errors++;
        $display("FAIL single_write_acc: got we %b addr %h wdata %h expected 1 12 beef",
                 acc_log[0].we, acc_log[0].addr, acc_log[0].wdata);
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_write_busy: got %b expected 0", busy); end
  endtask

  task automatic test_burst_read();
    bit ok;
    clear_logs(); ack_lat = 2;
    mem[8'hFE] = 16'h1111; mem[8'hFF] = 16'h2222; mem[8'h00] = 16'h3333;
    model_txn(16'h02FE);
    host_txn(16'h02FE, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL burst_read_done: got stuck expected idle"); end
    checks++;
    if (acc_log.size() != 3 || load_val.size() != 3) begin
      errors++;
      $display("FAIL burst_read_count: got %0d acc %0d loads expected 3 3", acc_log.size(), load_val.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (acc_log[i].we !== 1'b0 || acc_log[i].addr !== exp_acc[i].addr) begin
          errors++;
          $display("FAIL burst_read_addr[%0d]: got we %b addr %h expected 0 %h",
                   i, acc_log[i].we, acc_log[i].addr, exp_acc[i].addr);
        end
        checks++;
        if (load_val[i] !== exp_load[i]) begin
          errors++; $display("FAIL burst_read_data[%0d]: got %h expected %h", i, load_val[i], exp_load[i]);
        end
        checks++;
        if (load_cyc[i] - acc_log[i].cyc != 2) begin
          errors++;
          $display("FAIL burst_read_lat[%0d]: got %0d expected 2", i, load_cyc[i] - acc_log[i].cyc);
        end
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    clear_logs(); ack_lat = 4;
    send_word(16'h8034);
    send_word(16'h1234);
    send_word(16'h5555);   // lands while the write is still pending
    wait_until(2, 0, 64, ok);
    checks++;
    if (!ok || err_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_flag: got %b expected 1", err_overrun);
    end
    checks++;
    if (acc_log.size() != 1 || acc_log[0].wdata !== 16'h1234 || acc_log[0].addr !== 8'h34) begin
      errors++; $display("FAIL overrun_single_write: got %0d accesses expected 1", acc_log.size());
    end
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
    checks++;
    if (err_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", err_overrun); end
    // Clear in the same cycle as a new overrun must win.
    send_word(16'h8035);
    send_word(16'h4321);
    @(negedge clk); spi_word = 16'h7777; spi_word_valid = 1'b1; err_clear = 1'b1;
    @(negedge clk); spi_word_valid = 1'b0; err_clear = 1'b0;
    checks++;
    if (err_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear_prio: got %b expected 0", err_overrun); end
    wait_until(2, 0, 64, ok);
    checks++;
    if (!ok || acc_log.size() != 2) begin
      errors++; $display("FAIL overrun_second_write: got %0d accesses expected 2", acc_log.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int t0;
    int first;
    clear_logs(); ack_lat = 2; first = -1;
    @(negedge clk); spi_word = 16'h8100; spi_word_valid = 1'b1; t0 = cyc;
    @(negedge clk); spi_word_valid = 1'b0;
    for (int i = 0; i < 40 && first < 0; i++) begin
      if (err_timeout) first = cyc;
      else @(negedge clk);
    end
    checks++;
    if (first != t0 + 1 + TO) begin
      errors++; $display("FAIL timeout_cycle: got %0d expected %0d", first - t0, 1 + TO);
    end
    checks++;
    if (busy !== 1'b0 || acc_log.size() != 0) begin
      errors++; $display("FAIL timeout_idle: got busy %b acc %0d expected 0 0", busy, acc_log.size());
    end
    // A set flag must not block the next transaction.
    host_data.delete(); host_data.push_back(16'hA5A5); host_data.push_back(16'h5A5A);
    host_txn(16'h8140, ok);
    checks++;
    if (!ok || acc_log.size() != 2 || err_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_noblock: got %0d accesses expected 2", acc_log.size());
    end
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", err_timeout); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    clear_logs(); ack_lat = 8;
    send_word(16'h02FE);
    wait_until(3, 0, 16, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_req: got no request expected one"); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (reg_req !== 1'b0 || busy !== 1'b0 || spi_load !== 1'b0 || reg_addr !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got req %b busy %b load %b addr %h expected 0",
               reg_req, busy, spi_load, reg_addr);
    end
    reset = 1'b0; ack_lat = 2;
    @(negedge clk);
    clear_logs();
    host_data.delete(); host_data.push_back(16'hC0DE);
    host_txn(16'h8005, ok);
    checks++;
    if (!ok || acc_log.size() != 1 || acc_log[0].addr !== 8'h05 || acc_log[0].wdata !== 16'hC0DE) begin
      errors++; $display("FAIL midreset_recover: got %0d accesses expected 1 to 05", acc_log.size());
    end
  endtask

  task automatic test_max_burst();
    bit ok;
    clear_logs(); ack_lat = 0;
    host_data.delete();
    for (int i = 0; i < 128; i++) host_data.push_back(16'($urandom));
    model_txn(16'hFF00);
    host_txn(16'hFF00, ok);
    checks++;
    if (!ok || acc_log.size() != 128) begin
      errors++; $display("FAIL max_burst_count: got %0d expected 128", acc_log.size());
    end else begin
      for (int i = 0; i < 128; i++) begin
        checks++;
        if (acc_log[i].we !== 1'b1 || acc_log[i].addr !== exp_acc[i].addr || acc_log[i].wdata !== exp_acc[i].wdata) begin
          errors++;
          $display("FAIL max_burst[%0d]: got addr %h data %h expected %h %h",
                   i, acc_log[i].addr, acc_log[i].wdata, exp_acc[i].addr, exp_acc[i].wdata);
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [DW-1:0] cmd;
    for (int t = 0; t < 20; t++) begin
      clear_logs(); ack_lat = $urandom_range(0, 3);
      cmd = {1'($urandom), 7'($urandom_range(0, 5)), 8'($urandom)};
      host_data.delete();
      for (int i = 0; i <= int'(cmd[14:8]); i++) host_data.push_back(16'($urandom));
      model_txn(cmd);
      host_txn(cmd, ok);
      checks++;
      if (!ok || acc_log.size() != exp_acc.size() || load_val.size() != exp_load.size()) begin
        errors++;
        $display("FAIL random_count[%0d]: got %0d acc %0d loads expected %0d %0d",
                 t, acc_log.size(), load_val.size(), exp_acc.size(), exp_load.size());
        continue;
      end
      for (int i = 0; i < exp_acc.size(); i++) begin
        checks++;
        if (acc_log[i].we !== exp_acc[i].we || acc_log[i].addr !== exp_acc[i].addr ||
            (exp_acc[i].we && acc_log[i].wdata !== exp_acc[i].wdata)) begin
          errors++;
          $display("FAIL random_acc[%0d.%0d]: got %b %h %h expected %b %h %h", t, i,
                   acc_log[i].we, acc_log[i].addr, acc_log[i].wdata,
                   exp_acc[i].we, exp_acc[i].addr, exp_acc[i].wdata);
        end
      end
      for (int i = 0; i < exp_load.size(); i++) begin
        checks++;
        if (load_val[i] !== exp_load[i] || load_cyc[i] - acc_log[i].cyc != 2) begin
          errors++;
          $display("FAIL random_load[%0d.%0d]: got %h lat %0d expected %h lat 2",
                   t, i, load_val[i], load_cyc[i] - acc_log[i].cyc, exp_load[i]);
        end
      end
    end
    checks++;
    if (unstable != 0 || err_overrun !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL random_clean: got unstable %0d ovr %b to %b expected 0 0 0",
               unstable, err_overrun, err_timeout);
    end
  endtask

  initial begin
    reset = 1'b1; spi_word_valid = 1'b0; spi_word = '0; err_clear = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    test_reset();
    test_single_write();
    test_burst_read();
    test_overrun();
    test_timeout();
    test_reset_mid_burst();
    test_max_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
